sp_ram_fifo_ctrl: RTL and testbench

- FIFO controller that owns a single-port, read-first RAM with a 1-cycle registered read (our SpRamRf style: addr/we/din in, qout out).
- Sits directly upstream of the RAM, driving addr/we/din. Also sits downstream of it, consuming qout.
- Exposes valid/ready push and pop streams to the rest of the design.
- The RAM allows one access per cycle, so the block arbitrates writes against prefetch reads. Prefetched words land in a 2-entry output buffer.

---
 rtl/sp_ram_fifo_ctrl_if.sv | 29 ++
 rtl/sp_ram_fifo_ctrl.sv | 96 +++++++++
 tb/tb_sp_ram_fifo_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sp_ram_fifo_ctrl_if.sv
// Bundle of push/pop streams and single-port RAM bus for sp_ram_fifo_ctrl.
// The master side is the controller; the slave side is the surrounding logic
// (producer, consumer and the RAM macro).
interface sp_ram_fifo_ctrl_if #(
   parameter int AW = 8,
   parameter int DW = 8
);
   logic          push_valid;
   logic          push_ready;
   logic [DW-1:0] push_data;
   logic          pop_valid;
   logic          pop_ready;
   logic [DW-1:0] pop_data;
   logic [AW:0]   count;
   logic [AW-1:0] ram_addr;
   logic          ram_we;
   logic [DW-1:0] ram_din;
   logic [DW-1:0] ram_qout;

   modport master (
      input  push_valid, push_data, pop_ready, ram_qout,
      output push_ready, pop_valid, pop_data, count, ram_addr, ram_we, ram_din
   );

   modport slave (
      output push_valid, push_data, pop_ready, ram_qout,
      input  push_ready, pop_valid, pop_data, count, ram_addr, ram_we, ram_din
   );
endinterface

// File: rtl/sp_ram_fifo_ctrl.sv
// FIFO controller around a single-port read-first RAM with a registered read.
// One RAM access per cycle: writes from the push stream compete with prefetch
// reads that fill a 2-entry output buffer feeding the pop stream.
module sp_ram_fifo_ctrl #(
   parameter int AW = 8,
   parameter int DW = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   sp_ram_fifo_ctrl_if.master     bus
);
   localparam int DEPTH = 1 << AW;

   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [AW:0]           ram_cnt_q, ram_cnt_d;
   logic                  inflight_q, inflight_d;
   logic [1:0]            obuf_cnt_q, obuf_cnt_d;
   logic [1:0][DW-1:0]    obuf_q, obuf_d;
   logic [AW:0]           count_q, count_d;

   logic                  full, urgent, push_ready;
   logic                  do_wr, do_rd, do_pop;
   logic [1:0]            cnt_after_pop;

   // Arbitration terms; push_ready depends on registered state only.
   always_comb begin
      full       = (ram_cnt_q == (AW+1)'(DEPTH));
      urgent     = (obuf_cnt_q == 2'd0) && !inflight_q && (ram_cnt_q != '0);
      push_ready = !full && !urgent;
      do_wr      = bus.push_valid && push_ready;
      // urgent implies !push_ready, so a read never collides with a write
      do_rd      = urgent ||
                   (!do_wr && (ram_cnt_q != '0) &&
                    ((obuf_cnt_q + 2'(inflight_q)) < 2'd2));
      do_pop     = (obuf_cnt_q != 2'd0) && bus.pop_ready;
   end

   // Next-state: pointers, RAM occupancy, in-flight flag and output buffer.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      ram_cnt_d  = ram_cnt_q;
      obuf_d     = obuf_q;
      inflight_d = do_rd;
      if (do_wr) begin
         wr_ptr_d  = wr_ptr_q + 1'b1;
         ram_cnt_d = ram_cnt_q + 1'b1;
      end
      if (do_rd) begin
         rd_ptr_d  = rd_ptr_q + 1'b1;
         ram_cnt_d = ram_cnt_q - 1'b1;
      end
      // pop shifts first, then the captured word lands at the new tail
      cnt_after_pop = obuf_cnt_q - 2'(do_pop);
      if (do_pop) obuf_d[0] = obuf_q[1];
      if (inflight_q) begin
         if (cnt_after_pop == 2'd0) obuf_d[0] = bus.ram_qout;
         else                       obuf_d[1] = bus.ram_qout;
      end
      obuf_cnt_d = cnt_after_pop + 2'(inflight_q);
      count_d    = ram_cnt_d + (AW+1)'(inflight_d) + (AW+1)'(obuf_cnt_d);
   end

   // State registers; reset drops any in-flight read so its qout is ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         ram_cnt_q  <= '0;
         inflight_q <= 1'b0;
         obuf_cnt_q <= '0;
         obuf_q     <= '0;
         count_q    <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         ram_cnt_q  <= ram_cnt_d;
         inflight_q <= inflight_d;
         obuf_cnt_q <= obuf_cnt_d;
         obuf_q     <= obuf_d;
         count_q    <= count_d;
      end
   end

   // Outputs: the RAM address defaults to the read pointer when idle.
   always_comb begin
      bus.push_ready = push_ready;
      bus.pop_valid  = (obuf_cnt_q != 2'd0);
      bus.pop_data   = obuf_q[0];
      bus.count      = count_q;
      bus.ram_we     = do_wr;
      bus.ram_addr   = do_wr ? wr_ptr_q : rd_ptr_q;
      bus.ram_din    = bus.push_data;
   end
endmodule

// File: tb/tb_sp_ram_fifo_ctrl.sv
// Bench for sp_ram_fifo_ctrl with a small RAM (AW=2) so full and wrap cases
// are reached quickly. A queue-based model predicts every output each cycle.
module tb_sp_ram_fifo_ctrl;
   localparam int AW    = 2;
   localparam int DW    = 8;
   localparam int DEPTH = 1 << AW;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sp_ram_fifo_ctrl_if #(.AW(AW), .DW(DW)) bus ();

   sp_ram_fifo_ctrl #(.AW(AW), .DW(DW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Single-port read-first RAM, registered read, random power-up contents.
   logic [DW-1:0] mem [DEPTH];
   bit            mem_init = 1'b0;
   always @(posedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= DW'($urandom);
         mem_init <= 1'b1;
      end else begin
         bus.ram_qout <= mem[bus.ram_addr];
         if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
      end
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
   endtask

   // Model: words in RAM, one in-flight word, output buffer as queues.
   logic [DW-1:0] m_ram [$];
   logic [DW-1:0] m_obuf [$];
   bit            m_inf;
   logic [DW-1:0] m_inf_d;
   int            m_wp, m_rp;
   // DUT-observed bookkeeping
   logic [DW-1:0] got_q [$];
   int            acc_cnt;
   int            dut_wraps;

   initial begin
      bit e_pr, e_pv, e_wr, e_rd, e_urg;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            m_ram.delete(); m_obuf.delete();
            m_inf = 0; m_wp = 0; m_rp = 0;
            got_q.delete(); acc_cnt = 0; dut_wraps = 0;
         end else begin
            e_urg = (m_obuf.size() == 0) && !m_inf && (m_ram.size() != 0);
            e_pr  = (m_ram.size() != DEPTH) && !e_urg;
            e_pv  = (m_obuf.size() != 0);
            e_wr  = bus.push_valid && e_pr;
            e_rd  = e_urg || (!e_wr && m_ram.size() != 0 &&
                              (m_obuf.size() + int'(m_inf)) < 2);
            chk("push_ready", 32'(bus.push_ready), 32'(e_pr));
            chk("pop_valid",  32'(bus.pop_valid),  32'(e_pv));
            if (e_pv) chk("pop_data", 32'(bus.pop_data), 32'(m_obuf[0]));
            chk("count", 32'(bus.count), 32'(m_ram.size() + int'(m_inf) + m_obuf.size()));
            chk("ram_we", 32'(bus.ram_we), 32'(e_wr));
            chk("ram_addr", 32'(bus.ram_addr), 32'(e_wr ? m_wp : m_rp));
            chk("ram_din", 32'(bus.ram_din), 32'(bus.push_data));
            if (bus.push_valid && bus.push_ready) acc_cnt++;
            if (bus.ram_we && bus.ram_addr == AW'(DEPTH-1)) dut_wraps++;
            if (bus.pop_valid && bus.pop_ready) got_q.push_back(bus.pop_data);
            if (e_pv && bus.pop_ready) void'(m_obuf.pop_front());
            if (m_inf) m_obuf.push_back(m_inf_d);
            m_inf = e_rd;
            if (e_rd) begin
               m_inf_d = m_ram.pop_front();
               m_rp = (m_rp + 1) % DEPTH;
            end
            if (e_wr) begin
               m_ram.push_back(bus.push_data);
               m_wp = (m_wp + 1) % DEPTH;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.push_valid = 1'b0;
      bus.pop_ready  = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      step();
      rst_n = 1'b1;
   endtask

   task automatic push_one(input logic [DW-1:0] d);
      bit ok = 0;
      bus.push_valid = 1'b1;
      bus.push_data  = d;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.push_ready) ok = 1;
         step();
         if (ok) break;
      end
      bus.push_valid = 1'b0;
      chk("push_accepted", 32'(ok), 32'd1);
   endtask

   task automatic wait_pops(input string nm, input int n, input int maxcyc);
      for (int i = 0; i < maxcyc && got_q.size() < n; i++) step();
      chk(nm, 32'(got_q.size()), 32'(n));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [DW-1:0] exp3 [3];
      exp3[0] = 8'h10; exp3[1] = 8'h30; exp3[2] = 8'h60;
      bus.push_valid = 1'b0;
      bus.push_data  = '0;
      bus.pop_ready  = 1'b0;

      // 1: reset values, then asynchronous mid-cycle reset
      repeat (3) step();
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_push_ready", 32'(bus.push_ready), 32'd1);
      chk("rst_pop_valid",  32'(bus.pop_valid),  32'd0);
      chk("rst_count",      32'(bus.count),      32'd0);
      chk("rst_ram_we",     32'(bus.ram_we),     32'd0);
      step();
      bus.push_valid = 1'b1; bus.push_data = 8'h5A;
      repeat (5) step();
      bus.push_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("async_pop_valid", 32'(bus.pop_valid), 32'd0);
      chk("async_count",     32'(bus.count),     32'd0);
      chk("async_ram_we",    32'(bus.ram_we),    32'd0);
      @(negedge clk);
      step();
      rst_n = 1'b1;

      // 2: three back-to-back pushes, urgent-read stall and latency
      step();
      bus.push_valid = 1'b1; bus.push_data = 8'h10;
      @(negedge clk); chk("t2_first_ready", 32'(bus.push_ready), 32'd1);
      step();
      bus.push_data = 8'h30;
      @(negedge clk);
      chk("t2_stall", 32'(bus.push_ready), 32'd0);
      chk("t2_pv_early", 32'(bus.pop_valid), 32'd0);
      step();
      @(negedge clk); chk("t2_ready_again", 32'(bus.push_ready), 32'd1);
      step();
      bus.push_data = 8'h60;
      @(negedge clk);
      chk("t2_pv_k2", 32'(bus.pop_valid), 32'd1);
      chk("t2_head", 32'(bus.pop_data), 32'h10);
      step();
      bus.push_valid = 1'b0;
      repeat (4) step();
      @(negedge clk); chk("t2_count", 32'(bus.count), 32'd3);
      step();
      bus.pop_ready = 1'b1;
      wait_pops("t2_pops", 3, 20);
      for (int i = 0; i < 3 && i < got_q.size(); i++)
         chk("t2_order", 32'(got_q[i]), 32'(exp3[i]));

      // 3: fill to DEPTH+2, one pop, refill path reopens push
      do_reset();
      bus.push_valid = 1'b1; bus.push_data = '0;
      repeat (30) begin step(); bus.push_data = DW'(acc_cnt); end
      @(negedge clk);
      chk("t3_accepted", 32'(acc_cnt), 32'd6);
      chk("t3_count", 32'(bus.count), 32'd6);
      chk("t3_full", 32'(bus.push_ready), 32'd0);
      step();
      bus.pop_ready = 1'b1;
      step();
      bus.pop_ready = 1'b0;
      @(negedge clk); chk("t3_after_pop", 32'(bus.push_ready), 32'd0);
      step();
      @(negedge clk); chk("t3_refill_ready", 32'(bus.push_ready), 32'd1);
      step();
      @(negedge clk); chk("t3_seventh", 32'(acc_cnt), 32'd7);
      if (got_q.size() > 0) chk("t3_pop_word", 32'(got_q[0]), 32'h00);
      bus.push_valid = 1'b0;

      // 4: random handshakes, 20 words through a 4-deep RAM
      do_reset();
      for (int c = 0; c < 3000 && got_q.size() < 20; c++) begin
         step();
         bus.push_valid = (acc_cnt < 20) && ($urandom_range(1, 0) == 1);
         bus.push_data  = DW'(acc_cnt);
         bus.pop_ready  = ($urandom_range(1, 0) == 1);
      end
      bus.push_valid = 1'b0;
      chk("t4_pops", 32'(got_q.size()), 32'd20);
      for (int i = 0; i < got_q.size(); i++)
         chk("t4_order", 32'(got_q[i]), 32'(i));
      chk("t4_wraps_ge4", 32'(dut_wraps >= 4), 32'd1);

      // 5: continuous push and pop
      do_reset();
      bus.push_valid = 1'b1; bus.pop_ready = 1'b1; bus.push_data = 8'h40;
      repeat (40) begin step(); bus.push_data = DW'(8'h40 + acc_cnt); end
      bus.push_valid = 1'b0;
      wait_pops("t5_drain", acc_cnt, 40);
      chk("t5_progress", 32'(acc_cnt >= 15), 32'd1);
      for (int i = 0; i < got_q.size(); i++)
         chk("t5_order", 32'(got_q[i]), 32'(8'h40 + i));

      // 6: reset while a read is in flight
      do_reset();
      push_one(8'h77);
      step();
      #1 rst_n = 1'b0;
      @(negedge clk);
      step();
      rst_n = 1'b1;
      @(negedge clk);
      chk("t6_count", 32'(bus.count), 32'd0);
      chk("t6_pop_valid", 32'(bus.pop_valid), 32'd0);
      step();
      push_one(8'hA5);
      bus.pop_ready = 1'b1;
      wait_pops("t6_pop", 1, 20);
      if (got_q.size() > 0) chk("t6_first", 32'(got_q[0]), 32'hA5);
      bus.pop_ready = 1'b0;
      repeat (3) step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
